// File: rtl/playback_reader.sv
// playback_reader: read-side sequencer for the sample memory.
// Reads addresses 0 .. len-1 once per sample period (CLK_DIV cycles),
// presents each sample with a one-cycle strobe and pulses done at the end.
// Optional feature macro: PLAYBACK_LOOP_EN -- when defined, playback wraps
// back to address 0 after the last sample and repeats until stop.
module playback_reader #(
  parameter int CLK_DIV = 2083,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic [ADDR_W-1:0] rec_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                done_empty_q, done_empty_d;
  logic                at_last;

  // Current address is the final sample of the latched recording.
  assign at_last = (addr_q == (len_q - ADDR_W'(1)));

  // Next-state, address, divider and sample-capture logic.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    div_d        = div_q;
    sample_d     = sample_q;
    done_empty_d = 1'b0;

    // The divider free-runs while playing; it alone decides when WAIT ends.
    if (state_q != S_IDLE) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (play && !stop) begin
          if (rec_len != '0) begin
            len_d   = rec_len;
            addr_d  = '0;
            div_d   = '0;
            state_d = S_READ;
          end else begin
            done_empty_d = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        sample_d = mem_rdata;
        if (at_last) begin
`ifdef PLAYBACK_LOOP_EN
          addr_d  = '0;
          state_d = S_WAIT;
`else
          state_d = S_IDLE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_q == DIV_LAST) begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except the capture already under way.
    if (state_q != S_IDLE && stop) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      div_q        <= '0;
      sample_q     <= '0;
      done_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      div_q        <= div_d;
      sample_q     <= sample_d;
      done_empty_q <= done_empty_d;
    end
  end

  // Outputs decode from state; read data arrives during CAPTURE, so the
  // sample is forwarded from the memory in that cycle and held afterwards.
  assign mem_rd_en    = (state_q == S_READ);
  assign mem_addr     = addr_q;
  assign sample_valid = (state_q == S_CAPTURE);
  assign sample       = sample_valid ? mem_rdata : sample_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_empty_q | (sample_valid & at_last);

endmodule

// File: tb/tb_playback_reader.sv
// Testbench for playback_reader: directed scenarios plus randomized runs,
// each checked cycle by cycle against a schedule computed from the
// playback timing rules (read n at T+1+n*DIV, strobe at T+2+n*DIV).
module tb_playback_reader;

  localparam int CLK_DIV = 8;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  // Loop mode never ends on its own, so every run needs a stop.
  localparam int STOP_DEF = LOOP ? 40 : 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] rec_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              done;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [DATA_W-1:0] exp_sample = '0;

  playback_reader #(
    .CLK_DIV(CLK_DIV),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .play        (play),
    .stop        (stop),
    .rec_len     (rec_len),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory: data = address + 0x10, valid only the cycle after a read;
  // garbage otherwise so stale data cannot pass unnoticed.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {4'b0000, mem_addr} + 8'h10;
    else           mem_rdata <= 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string ctx, input bit busy_e, input bit rd_e,
                               input int addr_e, input bit valid_e, input bit done_e);
    check({ctx, ".busy"},   32'(busy),         32'(busy_e));
    check({ctx, ".rd_en"},  32'(mem_rd_en),    32'(rd_e));
    check({ctx, ".valid"},  32'(sample_valid), 32'(valid_e));
    check({ctx, ".done"},   32'(done),         32'(done_e));
    check({ctx, ".sample"}, 32'(sample),       32'(exp_sample));
    if (rd_e) check({ctx, ".addr"}, 32'(mem_addr), 32'(addr_e[ADDR_W-1:0]));
  endtask

  // Start playback in the current cycle T and check cycles T+1 .. horizon.
  // stop_at / collide_at are offsets from T (0 = not used).
  task automatic run_play(input string ctx, input int len, input int stop_at, input int collide_at);
    int  last_k, horizon, n_rd, n_v;
    bit  act, rd_e, valid_e, done_e;
    last_k  = 2 + CLK_DIV * (len - 1);
    horizon = (len == 0) ? 3 : (stop_at > 0 ? stop_at + 3 : last_k + 3);
    play    = 1'b1;
    stop    = 1'b0;
    rec_len = len[ADDR_W-1:0];
    for (int k = 1; k <= horizon; k++) begin
      tick();
      play    = (k == collide_at);
      stop    = (k == stop_at);
      rec_len = ADDR_W'($urandom);
      act     = (len != 0) && (stop_at <= 0 || k <= stop_at) && (LOOP || k <= last_k);
      rd_e    = act && ((k - 1) % CLK_DIV == 0);
      valid_e = act && (k >= 2) && ((k - 2) % CLK_DIV == 0);
      n_rd    = (k - 1) / CLK_DIV;
      n_v     = (k - 2) / CLK_DIV;
      done_e  = (len == 0) && (k == 1);
      if (valid_e) begin
        exp_sample = 8'((n_v % len) + 16);
        if ((n_v % len) == len - 1) done_e = 1'b1;
      end
      check_outputs($sformatf("%s@T+%0d", ctx, k), act, rd_e,
                    (len != 0) ? (n_rd % len) : 0, valid_e, done_e);
    end
    play = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    int len, last_k, stop_at, collide_at;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_outputs("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("reset.addr", 32'(mem_addr), 32'h0);

    // Single pass (loop mode: repeats until stop) and the two-sample case.
    run_play("single3", 3, STOP_DEF, 0);
    run_play("len2", 2, LOOP ? 30 : 0, 0);

    // Empty recording: done next cycle, nothing else.
    run_play("empty", 0, 0, 0);

    // Abort during the second sample's strobe cycle; sample holds 0x11.
    run_play("abort", 5, 10, 0);
    check("abort.sample_hold", 32'(sample), 32'h11);

    // play pulsed while busy is ignored.
    run_play("collide", 3, STOP_DEF, 5);

    // play and stop together in IDLE: no start.
    play    = 1'b1;
    stop    = 1'b1;
    rec_len = 4'd3;
    for (int k = 1; k <= 3; k++) begin
      tick();
      play = 1'b0;
      stop = 1'b0;
      check_outputs($sformatf("playstop@%0d", k), 1'b0, 1'b0, 0, 1'b0, 1'b0);
    end

    // Maximum length: addresses 0 .. 14.
    run_play("maxlen", 15, LOOP ? 130 : 0, 0);

    // Reset during WAIT returns everything to reset values.
    play    = 1'b1;
    rec_len = 4'd5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      play = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sample = '0;
    check_outputs("rst_wait", 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("rst_wait.addr", 32'(mem_addr), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_outputs($sformatf("rst_idle@%0d", k), 1'b0, 1'b0, 0, 1'b0, 1'b0);
    end

    // Randomized runs: length, optional abort point, optional busy play.
    for (int r = 0; r < 8; r++) begin
      tick();
      len     = int'($urandom_range(1, 15));
      last_k  = 2 + CLK_DIV * (len - 1);
      stop_at = (LOOP || $urandom_range(0, 2) == 0)
                ? int'($urandom_range(1, LOOP ? 2 * last_k + 8 : last_k)) : 0;
      collide_at = ($urandom_range(0, 1) == 0)
                   ? int'($urandom_range(1, stop_at > 0 ? stop_at : last_k)) : 0;
      run_play($sformatf("rand%0d_len%0d", r, len), len, stop_at, collide_at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
